survivor_mmu: RTL and testbench

Survivor-memory manager for the Viterbi decoder. It packs the per-cycle survivor decision bits from the ACS array into RAM words and writes them at a page/segment address. It also serves synchronous traceback reads from the same internal RAM. It sits between the ACS unit (write side) and the traceback unit (read side), and owns the survivor RAM.

---
 rtl/survivor_mmu.sv | 120 ++++++++++++
 tb/tb_survivor_mmu.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/survivor_mmu.sv
// survivor_mmu: survivor-memory manager for the Viterbi decoder.
// Packs two consecutive N_ACS-bit survivor slices into one RAM word, writes it
// at {page, segment}, and serves one-cycle registered traceback reads.
// Optional feature macro: WRITE_BYPASS_EN
//   defined   -> a same-cycle read of the address being written returns the new word
//   undefined -> such a read returns the previous RAM contents
//
// Packing phase (segment LSB):
//   state   | meaning
//   PH_LOW  | next enabled cycle latches Survivors into the low buffer
//   PH_HIGH | next enabled cycle writes {Survivors, low buffer} to RAM
module survivor_mmu #(
    parameter int WD_DEPTH       = 4,
    parameter int WD_FSM         = 6,
    parameter int N_ACS          = 4,
    parameter int WD_RAM_DATA    = 8,
    parameter int WD_RAM_ADDRESS = 9
) (
    input  logic                      CLOCK,
    input  logic                      Reset,
    input  logic                      Active,
    input  logic                      Hold,
    input  logic                      Init,
    input  logic [WD_DEPTH-1:0]       ACSPage,
    input  logic [WD_FSM-2:0]         ACSSegment_minusLSB,
    input  logic [N_ACS-1:0]          Survivors,
    input  logic [WD_RAM_ADDRESS-1:0] AddressTB,
    output logic [WD_RAM_DATA-1:0]    DataTB,
    output logic                      RAMWrite,
    output logic [WD_RAM_ADDRESS-1:0] AddressRAM
);

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_t;

    phase_t                      phase_q;
    phase_t                      phase_d;
    logic                        en;
    logic                        latch_en;
    logic                        wr_en;
    logic [N_ACS-1:0]            low_buffer;
    logic [WD_RAM_ADDRESS-1:0]   wr_addr;
    logic [WD_RAM_DATA-1:0]      wr_data;
    logic [WD_RAM_DATA-1:0]      rd_data;
    logic [WD_RAM_DATA-1:0]      mem [0:(1<<WD_RAM_ADDRESS)-1];

    assign en      = Active & ~Hold;
    assign wr_addr = {ACSPage, ACSSegment_minusLSB};
    assign wr_data = {Survivors, low_buffer};

    // Phase register: cleared by reset, otherwise follows the next-phase logic.
    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            phase_q <= PH_LOW;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Next phase and latch/write strobes; Init acts on the phase after the
    // strobes have been decided from the pre-Init phase.
    always_comb begin
        phase_d  = phase_q;
        latch_en = 1'b0;
        wr_en    = 1'b0;
        if (en) begin
            if (phase_q == PH_LOW) begin
                latch_en = 1'b1;
                phase_d  = PH_HIGH;
            end else begin
                wr_en    = 1'b1;
                phase_d  = PH_LOW;
            end
        end
        if (Init) begin
            phase_d = PH_LOW;
        end
    end

    // Read-port data selection, with optional write-first forwarding.
    always_comb begin
        rd_data = mem[AddressTB];
`ifdef WRITE_BYPASS_EN
        if (wr_en && (wr_addr == AddressTB)) begin
            rd_data = wr_data;
        end
`endif
    end

    // Survivor RAM write port; contents are intentionally not reset.
    always_ff @(posedge CLOCK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Low buffer, write-status outputs and registered traceback read data.
    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            low_buffer <= '0;
            RAMWrite   <= 1'b0;
            AddressRAM <= '0;
            DataTB     <= '0;
        end else begin
            RAMWrite <= wr_en;
            if (latch_en) begin
                low_buffer <= Survivors;
            end
            if (wr_en) begin
                AddressRAM <= wr_addr;
            end
            if (en) begin
                DataTB <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_survivor_mmu.sv
// tb_survivor_mmu: directed scenarios plus randomized traffic for survivor_mmu,
// checked against a pair-queue reference model of the survivor memory.
module tb_survivor_mmu;

    localparam int WD_DEPTH       = 4;
    localparam int WD_FSM         = 6;
    localparam int N_ACS          = 4;
    localparam int WD_RAM_DATA    = 8;
    localparam int WD_RAM_ADDRESS = 9;
    localparam int DEPTH          = 1 << WD_RAM_ADDRESS;

`ifdef WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                      CLOCK = 1'b0;
    logic                      Reset = 1'b0;
    logic                      Active = 1'b0;
    logic                      Hold = 1'b0;
    logic                      Init = 1'b0;
    logic [WD_DEPTH-1:0]       ACSPage = '0;
    logic [WD_FSM-2:0]         ACSSegment_minusLSB = '0;
    logic [N_ACS-1:0]          Survivors = '0;
    logic [WD_RAM_ADDRESS-1:0] AddressTB = '0;
    logic [WD_RAM_DATA-1:0]    DataTB;
    logic                      RAMWrite;
    logic [WD_RAM_ADDRESS-1:0] AddressRAM;

    survivor_mmu #(
        .WD_DEPTH      (WD_DEPTH),
        .WD_FSM        (WD_FSM),
        .N_ACS         (N_ACS),
        .WD_RAM_DATA   (WD_RAM_DATA),
        .WD_RAM_ADDRESS(WD_RAM_ADDRESS)
    ) dut (
        .CLOCK              (CLOCK),
        .Reset              (Reset),
        .Active             (Active),
        .Hold               (Hold),
        .Init               (Init),
        .ACSPage            (ACSPage),
        .ACSSegment_minusLSB(ACSSegment_minusLSB),
        .Survivors          (Survivors),
        .AddressTB          (AddressTB),
        .DataTB             (DataTB),
        .RAMWrite           (RAMWrite),
        .AddressRAM         (AddressRAM)
    );

    always #5 CLOCK = ~CLOCK;

    int checks   = 0;
    int failures = 0;

    // Reference model: survivor slices accumulate in a queue; two slices make a word.
    logic [WD_RAM_DATA-1:0] m_mem [DEPTH];
    bit                     m_ok  [DEPTH];
    logic [N_ACS-1:0]       pend [$];
    logic [WD_RAM_DATA-1:0] e_dt = '0;
    bit                     e_dt_ok = 1'b1;
    bit                     e_rw = 1'b0;
    logic [WD_RAM_ADDRESS-1:0] e_ar = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        e_dt    = '0;
        e_dt_ok = 1'b1;
        e_rw    = 1'b0;
        e_ar    = '0;
    endtask

    task automatic check_outputs();
        chk("ramwrite", 32'(RAMWrite), 32'(e_rw));
        chk("addressram", 32'(AddressRAM), 32'(e_ar));
        if (e_dt_ok) chk("datatb", 32'(DataTB), 32'(e_dt));
    endtask

    // One clock: drive inputs, advance the model on the edge, check 1 time unit later.
    task automatic cycle(input int a, input int h, input int i, input int pg,
                         input int sg, input int sv, input int atb);
        logic [WD_RAM_ADDRESS-1:0] wa;
        logic [WD_RAM_ADDRESS-1:0] ra;
        logic [WD_RAM_DATA-1:0]    w;
        bit                        wr;
        Active              = (a != 0);
        Hold                = (h != 0);
        Init                = (i != 0);
        ACSPage             = WD_DEPTH'(pg);
        ACSSegment_minusLSB = (WD_FSM-1)'(sg);
        Survivors           = N_ACS'(sv);
        AddressTB           = WD_RAM_ADDRESS'(atb);
        @(posedge CLOCK);
        wa = {ACSPage, ACSSegment_minusLSB};
        ra = AddressTB;
        wr = 1'b0;
        w  = '0;
        if (Active && !Hold) begin
            pend.push_back(Survivors);
            if (pend.size() == 2) begin
                wr = 1'b1;
                w  = {pend[1], pend[0]};
                pend.delete();
            end
            if (wr && BYPASS && (wa == ra)) begin
                e_dt    = w;
                e_dt_ok = 1'b1;
            end else begin
                e_dt    = m_mem[ra];
                e_dt_ok = m_ok[ra];
            end
            if (wr) begin
                m_mem[wa] = w;
                m_ok[wa]  = 1'b1;
                e_ar      = wa;
            end
        end
        e_rw = wr;
        if (Init) pend.delete();
        #1;
        check_outputs();
    endtask

    // Asynchronous reset pulse issued between clock edges.
    task automatic async_reset(input string tag);
        #1;
        Reset = 1'b0;
        #1;
        model_reset();
        chk({tag, "_rst_datatb"}, 32'(DataTB), 32'h0);
        chk({tag, "_rst_ramwrite"}, 32'(RAMWrite), 32'h0);
        chk({tag, "_rst_addressram"}, 32'(AddressRAM), 32'h0);
        @(negedge CLOCK);
        Reset = 1'b1;
    endtask

    initial begin
        logic [WD_RAM_DATA-1:0] frozen;
        logic [WD_RAM_DATA-1:0] exp_w;
        for (int k = 0; k < DEPTH; k++) begin
            m_mem[k] = '0;
            m_ok[k]  = 1'b0;
        end
        model_reset();

        repeat (2) @(posedge CLOCK);
        #1;
        chk("reset_datatb", 32'(DataTB), 32'h0);
        chk("reset_ramwrite", 32'(RAMWrite), 32'h0);
        chk("reset_addressram", 32'(AddressRAM), 32'h0);
        @(negedge CLOCK);
        Reset = 1'b1;

        // First pair: Survivors 1 then 2 at page 0, segment 0.
        cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 2, 0);
        chk("pair1_ramwrite", 32'(RAMWrite), 32'h1);
        chk("pair1_addr", 32'(AddressRAM), 32'h0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        chk("pair1_read", 32'(DataTB), 32'h21);

        // Fill page 0, then read it back while writing elsewhere.
        cycle(0, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 64; k++) cycle(1, 0, 0, 0, k / 2, k, 0);
        for (int k = 0; k < 32; k++) begin
            cycle(1, 0, 0, 15, k, 0, k);
            exp_w = {4'((2 * k + 1) & 15), 4'((2 * k) & 15)};
            chk("fill_read", 32'(DataTB), 32'(exp_w));
        end

        // Hold between the two halves of a pair.
        cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 3, 5, 1);
        frozen = DataTB;
        for (int k = 0; k < 3; k++) begin
            cycle(1, 1, 0, 0, 3, 12, 2);
            chk("hold_datatb_frozen", 32'(DataTB), 32'(frozen));
        end
        cycle(1, 0, 0, 0, 3, 9, 1);
        chk("hold_write", 32'(RAMWrite), 32'h1);
        cycle(1, 0, 0, 0, 3, 0, 3);
        chk("hold_read", 32'(DataTB), 32'h95);

        // Active low blocks everything.
        frozen = DataTB;
        for (int k = 0; k < 5; k++) begin
            cycle(0, 0, 0, 0, k, k + 6, k);
            chk("inactive_datatb", 32'(DataTB), 32'(frozen));
        end
        for (int k = 0; k < 4; k++) cycle(1, 0, 0, 15, 0, 0, k);

        // Same-cycle read and write of address 0x1F.
        cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 31, 0, 0);
        cycle(1, 0, 0, 0, 31, 0, 0);
        cycle(1, 0, 0, 0, 31, 4'hB, 0);
        cycle(1, 0, 0, 0, 31, 4'hA, 9'h1F);
        chk("same_cycle_rw", 32'(DataTB), BYPASS ? 32'hAB : 32'h00);
        cycle(1, 0, 0, 15, 0, 0, 9'h1F);
        cycle(1, 0, 0, 15, 0, 0, 9'h1F);
        chk("same_cycle_after", 32'(DataTB), 32'hAB);

        // Reset after phase 0 discards the half pair.
        cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 7, 3, 0);
        async_reset("midpair");
        cycle(1, 0, 0, 0, 7, 4, 0);
        chk("midpair_no_write", 32'(RAMWrite), 32'h0);
        cycle(1, 0, 0, 0, 7, 5, 0);
        chk("midpair_write", 32'(RAMWrite), 32'h1);
        cycle(1, 0, 0, 0, 0, 0, 7);
        chk("midpair_read", 32'(DataTB), 32'h54);

        // Randomized traffic on pages 0..1.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rand");
            end else begin
                cycle(($urandom_range(0, 7) != 0) ? 1 : 0,
                      ($urandom_range(0, 5) == 0) ? 1 : 0,
                      ($urandom_range(0, 30) == 0) ? 1 : 0,
                      int'($urandom_range(0, 1)),
                      int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 63)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
